// File: rtl/tdm_mux4.sv
// rtl/tdm_mux4.sv - four-lane valid/ready collector onto one tagged, registered output stream
// Define TDM_MUX4_FIXED_PRIO_EN for lowest-index-first arbitration; default is round-robin.
module tdm_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] lane [4];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       grant_idx;
    logic             grant_any;
    logic             slot_free;
    logic             accept;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = in_data[i*WIDTH +: WIDTH];
    end

`ifdef TDM_MUX4_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid lane wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = 2'(k);
            end
        end
    end
`else
    logic [1:0] last_q, last_d;
    logic [1:0] cand;

    // Search starts one past the last grant; 2-bit addition provides the 3->0 wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        last_d = accept ? grant_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = enable && slot_free && grant_any;
    assign in_ready  = accept ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane[grant_idx];
            out_sel_d   = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/tdm_mux4.md
# tdm_mux4

Four-channel collector that merges four valid/ready input lanes onto one registered output stream. Each word is tagged with the 2-bit channel index it came from, so a downstream 1-to-4 demultiplexer can route it back to the matching lane. The block sits at the gathering end of a four-lane datapath. It arbitrates round-robin and sustains one word per cycle.

## Interface
- WIDTH, 8, data width of each lane and of the output
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  when low, no new inputs are accepted; a word already in the output register still drains
- in_data  input  4*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  4  per-lane valid
- in_ready  output  4  per-lane ready, combinational, at most one bit high (one-hot)
- out_data  output  WIDTH  registered output word
- out_sel  output  2  registered index of the source lane of out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready

## Operation
- Clock and reset: single clock domain `clk`; synchronous, active-high reset `rst`.
- Reset values: out_valid=0, out_data=0, out_sel=2'b00, last-grant pointer=3 (lane 0 has first priority).
- Output slot is free when `!out_valid || out_ready`.
- Grant: the first lane with in_valid=1, searching from last+1 upward modulo 4 (wraps 3→0).
- in_ready[g]=1 only when enable=1, the slot is free and g is the granted lane; all other in_ready bits are 0.
- Transfer: on a clock edge with in_valid[g] && in_ready[g]:
  - out_data <= lane g data
  - out_sel <= g
  - out_valid <= 1
  - last <= g
- Drain only: if out_valid && out_ready and no input is accepted, then out_valid <= 0. out_data and out_sel keep their values.
- Stall: while out_valid && !out_ready, out_data, out_sel and out_valid are held and all in_ready are 0.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one and out_valid stays 1, giving full throughput.
- The last-grant pointer changes only on a transfer.
- enable low: no transfers and the pointer is frozen. The pending output is still presented and can be consumed.
- Reset mid-operation: a pending output word is discarded and all registers return to their reset values on the next edge.

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one word per cycle with out_ready held high.
- With all four lanes continuously valid, grants run 0,1,2,3,0,… with no lane granted twice before every other requesting lane has been granted once.
- in_ready depends combinationally on in_valid, out_valid, out_ready and enable. There is no combinational path from in_data to any output.

## Configuration
- Macro: TDM_MUX4_FIXED_PRIO_EN.
- Defined: fixed priority. The grant goes to the lowest-index valid lane, lane 0 highest. The pointer register is not built. Starvation of higher-index lanes is permitted.
- Undefined (default): round-robin as described in Operation.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset then single lane: in_valid=4'b0100, lane 2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- All lanes valid, data 8'h10/8'h11/8'h12/8'h13, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle. Fixed-priority build: all 0.
- Backpressure: out_ready=0 for 3 cycles while lanes 1 and 3 are valid → out_data/out_sel held and in_ready=0. On release, the pending word is consumed, lane 1 or 3 is loaded in the same cycle, and no word is lost or duplicated.
- Wrap-around: last grant=3, in_valid=4'b1001 → lane 0 granted, then lane 3.
- enable=0 with in_valid=4'b1111 and a pending output → the pending word drains, out_valid falls to 0, in_ready stays 0, and the pointer is unchanged once enable returns.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_sel=0, and lane 0 is granted first afterwards.
